// File: rtl/lutram_wr_arbiter_pkg.sv
// Shared types for the lutram write-port arbiter: FSM state and requester index.
// Optional post-reset clear is enabled with LUTRAM_WR_ARBITER_INIT_EN.
package lutram_wr_arbiter_pkg;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_t;

    typedef logic req_idx_t;

    localparam req_idx_t REQ0 = 1'b0;
    localparam req_idx_t REQ1 = 1'b1;

    // After a grant, priority passes to the requester that was not served.
    function automatic req_idx_t other_req(input req_idx_t idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/lutram_rr_pick.sv
// Two-way round-robin grant logic with its priority pointer register.
// Grants are combinational; the pointer advances only when a grant is issued.
module lutram_rr_pick
    import lutram_wr_arbiter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic grant0_o,
    output logic grant1_o
);

    req_idx_t ptr_q;

    // A lone requester always wins; on contention the pointer owner wins.
    always_comb begin
        grant0_o = 1'b0;
        grant1_o = 1'b0;
        if (en_i) begin
            grant0_o = valid0_i && (!valid1_i || (ptr_q == REQ0));
            grant1_o = valid1_i && (!valid0_i || (ptr_q == REQ1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= REQ0;
        end else if (grant0_o) begin
            ptr_q <= other_req(REQ0);
        end else if (grant1_o) begin
            ptr_q <= other_req(REQ1);
        end
    end

endmodule

// File: rtl/lutram_wr_arbiter.sv
// Round-robin sharing of the lutram write port between two valid/ready requesters,
// with an optional clear of every location after reset (LUTRAM_WR_ARBITER_INIT_EN).
module lutram_wr_arbiter
    import lutram_wr_arbiter_pkg::*;
#(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req0_valid_i,
    input  logic [RAM_ADDR_BITS-1:0] req0_addr_i,
    input  logic [RAM_WIDTH-1:0]     req0_data_i,
    output logic                     req0_ready_o,
    input  logic                     req1_valid_i,
    input  logic [RAM_ADDR_BITS-1:0] req1_addr_i,
    input  logic [RAM_WIDTH-1:0]     req1_data_i,
    output logic                     req1_ready_o,
    output logic                     ram_we_o,
    output logic [RAM_ADDR_BITS-1:0] ram_waddr_o,
    output logic [RAM_WIDTH-1:0]     ram_wdata_o,
    output logic                     init_done_o,
    output state_t                   dbg_state_o
);

    localparam int RAM_DEPTH = 2 ** RAM_ADDR_BITS;
    localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(RAM_DEPTH - 1);

`ifdef LUTRAM_WR_ARBITER_INIT_EN
    localparam state_t RESET_STATE = INIT;
`else
    localparam state_t RESET_STATE = ARB;
`endif

    state_t                   state_q;
    logic [RAM_ADDR_BITS-1:0] init_cnt_q;
    logic                     grant0;
    logic                     grant1;

    // Handshake: a write transfers when valid and ready are both high at a posedge.
    // Requesters hold valid/addr/data until ready, and valid never waits on ready.
    // Ready only opens once init_done_o is high, so no grant overlaps the clear.
    lutram_rr_pick u_pick (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (init_done_o),
        .valid0_i (req0_valid_i),
        .valid1_i (req1_valid_i),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign dbg_state_o  = state_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= RESET_STATE;
            init_cnt_q  <= '0;
            ram_we_o    <= 1'b0;
            ram_waddr_o <= '0;
            ram_wdata_o <= '0;
            init_done_o <= 1'b0;
        end else begin
            init_done_o <= (state_q == ARB);
            case (state_q)
                INIT: begin
                    ram_we_o    <= 1'b1;
                    ram_waddr_o <= init_cnt_q;
                    ram_wdata_o <= '0;
                    init_cnt_q  <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LAST_ADDR) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    // Address and data hold their last value on idle cycles.
                    if (grant0) begin
                        ram_we_o    <= 1'b1;
                        ram_waddr_o <= req0_addr_i;
                        ram_wdata_o <= req0_data_i;
                    end else if (grant1) begin
                        ram_we_o    <= 1'b1;
                        ram_waddr_o <= req1_addr_i;
                        ram_wdata_o <= req1_data_i;
                    end else begin
                        ram_we_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
